wr_port_arbiter: RTL

WR_PORT_ARBITER -- requirements
Module: wr_port_arbiter

---
 rtl/wr_port_arbiter.sv | 92 +++++++++
 1 files changed

// File: rtl/wr_port_arbiter.sv
// wr_port_arbiter: round-robin burst arbiter merging NREQ producers onto a single FIFO write port
module wr_port_arbiter #(
    parameter int NREQ  = 4,
    parameter int DW    = 32,
    parameter int BURST = 4
) (
    input  logic                    w_clk,
    input  logic                    wrst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*DW-1:0]      req_data,
    output logic [NREQ-1:0]         req_ack,
    input  logic                    fifo_full,
    output logic                    wr_req,
    output logic [DW-1:0]           data_in,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    busy,
    output logic [15:0]             xfer_cnt
);
    localparam int OW = $clog2(NREQ);
    localparam int CW = $clog2(BURST) + 1;

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t        state_q, state_d;
    logic [OW-1:0] owner_q, owner_d, last_q, last_d, winner, idx;
    logic [CW-1:0] bcnt_q, bcnt_d;
    logic [15:0]   xfer_cnt_q, xfer_cnt_d;
    logic          xfer;
    logic [DW-1:0] lane [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign lane[i] = req_data[i*DW +: DW];
    end

    // Scan from farthest to nearest so the requester closest after last_q wins
    always_comb begin
        winner = last_q;
        idx    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = OW'((int'(last_q) + k) % NREQ);
            if (req[idx]) winner = idx;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        bcnt_d     = bcnt_q;
        xfer_cnt_d = xfer_cnt_q;
        xfer       = (state_q == S_BURST) && req[owner_q] && !fifo_full;
        if (state_q == S_IDLE) begin
            if (|req) begin
                state_d = S_BURST;
                owner_d = winner;
                bcnt_d  = '0;
            end
        end else begin
            if (xfer) begin
                bcnt_d     = bcnt_q + 1'b1;
                xfer_cnt_d = (&xfer_cnt_q) ? xfer_cnt_q : xfer_cnt_q + 16'd1;
            end
            if ((xfer && bcnt_q == CW'(BURST - 1)) || !req[owner_q]) begin
                state_d = S_IDLE;
                last_d  = owner_q;
            end
        end
    end

    always_ff @(posedge w_clk or negedge wrst) begin
        if (!wrst) begin
            state_q    <= S_IDLE;
            owner_q    <= '0;
            last_q     <= OW'(NREQ - 1);
            bcnt_q     <= '0;
            xfer_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            bcnt_q     <= bcnt_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign busy     = state_q == S_BURST;
    assign wr_req   = xfer;
    assign req_ack  = {{(NREQ-1){1'b0}}, xfer} << owner_q;
    assign data_in  = busy ? lane[owner_q] : '0;
    assign owner    = owner_q;
    assign xfer_cnt = xfer_cnt_q;
endmodule
